// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing defaults, derived line/frame positions and the
// phase type shared by the horizontal and vertical sequencers.
package vga_pkg;

  localparam int unsigned CNT_W       = 10;
  localparam int unsigned DEF_CLK_DIV = 4;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync windows as [start, end) positions
  localparam int unsigned DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FP     = 2'd1,
    SYNC   = 2'd2,
    BP     = 2'd3
  } phase_t;

  // Counter value of the last position before boundary 'pos'
  function automatic logic [CNT_W-1:0] cnt_last(input int unsigned pos);
    return CNT_W'(pos - 1);
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: free-running 0..CLK_DIV-1 counter with a one-clk
// pix_tick while the counter sits on its last value.
module vga_pix_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Gated by rst so the strobe is quiet during reset even when CLK_DIV = 1
  assign pix_tick = (div == DIV_LAST) && !rst;

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA timing generator: pixel/line counters, horizontal and vertical phase
// sequencers, and a pixel-delayed sync/colour output stage.
module vga_sync_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       pix_r,
  input  logic [3:0]       pix_g,
  input  logic [3:0]       pix_b,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             pix_tick,
  output logic             video_on,
  output logic             frame_start,
  output logic             Hsync,
  output logic             Vsync,
  output logic [3:0]       Red,
  output logic [3:0]       Green,
  output logic [3:0]       Blue
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last count value inside each phase; the phase changes on the following tick
  localparam logic [CNT_W-1:0] H_ACT_LAST  = cnt_last(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_FP_LAST   = cnt_last(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_LAST = cnt_last(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST      = cnt_last(H_TOTAL);
  localparam logic [CNT_W-1:0] V_ACT_LAST  = cnt_last(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_FP_LAST   = cnt_last(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_LAST = cnt_last(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST      = cnt_last(V_TOTAL);

  phase_t hstate, hstate_nxt;
  phase_t vstate, vstate_nxt;
  logic   line_end;
  logic   hsync_c;
  logic   vsync_c;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (pix_tick)
  );

  assign line_end = (hcount == H_LAST);

  // Pixel and line counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_tick) begin
      if (line_end) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + CNT_W'(1);
      end else begin
        hcount <= hcount + CNT_W'(1);
      end
    end
  end

  // Phase state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hstate <= ACTIVE;
      vstate <= ACTIVE;
    end else begin
      hstate <= hstate_nxt;
      vstate <= vstate_nxt;
    end
  end

  // Phase transitions track the counter value being left on this tick
  always_comb begin
    hstate_nxt = hstate;
    vstate_nxt = vstate;
    if (pix_tick) begin
      unique case (hstate)
        ACTIVE: if (hcount == H_ACT_LAST)  hstate_nxt = FP;
        FP:     if (hcount == H_FP_LAST)   hstate_nxt = SYNC;
        SYNC:   if (hcount == H_SYNC_LAST) hstate_nxt = BP;
        BP:     if (line_end)              hstate_nxt = ACTIVE;
      endcase
      if (line_end) begin
        unique case (vstate)
          ACTIVE: if (vcount == V_ACT_LAST)  vstate_nxt = FP;
          FP:     if (vcount == V_FP_LAST)   vstate_nxt = SYNC;
          SYNC:   if (vcount == V_SYNC_LAST) vstate_nxt = BP;
          BP:     if (vcount == V_LAST)      vstate_nxt = ACTIVE;
        endcase
      end
    end
  end

  // Phase decode
  always_comb begin
    video_on = 1'b0;
    hsync_c  = ~SYNC_POL;
    vsync_c  = ~SYNC_POL;
    if ((hstate == ACTIVE) && (vstate == ACTIVE)) video_on = 1'b1;
    if (hstate == SYNC) hsync_c = SYNC_POL;
    if (vstate == SYNC) vsync_c = SYNC_POL;
  end

  assign frame_start = pix_tick && (hcount == '0) && (vcount == '0);

  // Output stage: one pixel behind the counters, sync and colour aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Hsync <= ~SYNC_POL;
      Vsync <= ~SYNC_POL;
      Red   <= '0;
      Green <= '0;
      Blue  <= '0;
    end else if (pix_tick) begin
      Hsync <= hsync_c;
      Vsync <= vsync_c;
      Red   <= video_on ? pix_r : 4'h0;
      Green <= video_on ? pix_g : 4'h0;
      Blue  <= video_on ? pix_b : 4'h0;
    end
  end

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl: a default-timing instance for line-level timing and
// a shrunken instance (24x12, /3, active-high sync) for frame-level behaviour.
module tb_vga_sync_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pix_r, pix_g, pix_b;

  logic [9:0] d_hcount, d_vcount, s_hcount, s_vcount;
  logic       d_tick, d_vid, d_fs, d_hs, d_vs;
  logic       s_tick, s_vid, s_fs, s_hs, s_vs;
  logic [3:0] d_red, d_green, d_blue, s_red, s_green, s_blue;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_sync_ctrl dut_d (
    .clk(clk), .rst(rst), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .hcount(d_hcount), .vcount(d_vcount), .pix_tick(d_tick), .video_on(d_vid),
    .frame_start(d_fs), .Hsync(d_hs), .Vsync(d_vs),
    .Red(d_red), .Green(d_green), .Blue(d_blue)
  );

  vga_sync_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(3), .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .hcount(s_hcount), .vcount(s_vcount), .pix_tick(s_tick), .video_on(s_vid),
    .frame_start(s_fs), .Hsync(s_hs), .Vsync(s_vs),
    .Red(s_red), .Green(s_green), .Blue(s_blue)
  );

  typedef struct {
    int         h;
    int         v;
    logic [3:0] r, g, b;
    logic       vid, fs, hs, vs;
    logic [3:0] er, eg, eb;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic seek_d(input int h, input int v, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (d_tick && d_hcount == 10'(h) && d_vcount == 10'(v)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic seek_s(input int h, input int v, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (s_tick && s_hcount == 10'(h) && s_vcount == 10'(v)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Rising edge (counted from reset release) that consumes the first tick
  task automatic first_ticks(output int de, output int se, output int dfs,
                             output int sfs, output int dhv);
    de = -1; se = -1; dfs = 0; sfs = 0; dhv = -1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (d_tick && de < 0) begin
        de  = e + 1;
        dfs = int'(d_fs);
        dhv = int'(d_hcount) + int'(d_vcount);
      end
      if (s_tick && se < 0) begin
        se  = e + 1;
        sfs = int'(s_fs);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    bit         prev_tick;
    int         de, se, dfs, sfs, dhv;
    int         clks, ticks, hs_low, first_low, red_nz, blue_a, green_nz, vid, hold_err;
    int         vs_lines, first_vs;
    logic [13:0] prev_o, cur_o;

    vecs[0]  = '{0,  0,  4'hF, 4'h0, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 4'hA};
    vecs[1]  = '{15, 0,  4'h1, 4'h2, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 4'h2, 4'h3};
    vecs[2]  = '{16, 0,  4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
    vecs[3]  = '{17, 0,  4'h4, 4'h4, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
    vecs[4]  = '{18, 0,  4'h5, 4'h6, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
    vecs[5]  = '{21, 0,  4'h5, 4'h6, 4'h7, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
    vecs[6]  = '{22, 0,  4'h5, 4'h6, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
    vecs[7]  = '{23, 0,  4'h5, 4'h6, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
    vecs[8]  = '{0,  1,  4'h9, 4'h8, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 4'h8, 4'h7};
    vecs[9]  = '{5,  5,  4'hC, 4'hD, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 4'hC, 4'hD, 4'hE};
    vecs[10] = '{5,  6,  4'hC, 4'hD, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
    vecs[11] = '{0,  8,  4'hC, 4'hD, 4'hE, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
    vecs[12] = '{19, 9,  4'hC, 4'hD, 4'hE, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
    vecs[13] = '{0,  10, 4'hC, 4'hD, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
    vecs[14] = '{23, 11, 4'hC, 4'hD, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
    vecs[15] = '{0,  0,  4'h3, 4'h3, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 4'h3, 4'h3};

    // Reset state
    rst = 1'b1; pix_r = 4'h0; pix_g = 4'h0; pix_b = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_d_hcount", d_hcount, 0);
    check("rst_d_vcount", d_vcount, 0);
    check("rst_d_tick", d_tick, 0);
    check("rst_d_fs", d_fs, 0);
    check("rst_d_hsync", d_hs, 1);
    check("rst_d_vsync", d_vs, 1);
    check("rst_d_rgb", {d_red, d_green, d_blue}, 0);
    check("rst_s_tick", s_tick, 0);
    check("rst_s_hsync", s_hs, 0);
    check("rst_s_vsync", s_vs, 0);

    // First tick after release
    rst = 1'b0;
    first_ticks(de, se, dfs, sfs, dhv);
    check("first_tick_edge_d", de, 4);
    check("first_tick_fs_d", dfs, 1);
    check("first_tick_pos_d", dhv, 0);
    check("first_tick_edge_s", se, 3);
    check("first_tick_fs_s", sfs, 1);

    // One full default line with constant colour F/0/A
    pix_r = 4'hF; pix_g = 4'h0; pix_b = 4'hA;
    seek_d(0, 1, 4000, ok);
    check("seek_line_start", ok, 1);
    clks = 0; ticks = 0; hs_low = 0; first_low = -1; red_nz = 0; blue_a = 0;
    green_nz = 0; vid = 0; hold_err = 0; prev_tick = 1'b1; prev_o = '0;
    do begin
      cur_o = {d_hs, d_vs, d_red, d_green, d_blue};
      if (d_tick) begin
        ticks++;
        if (!d_hs) begin
          hs_low++;
          if (first_low < 0) first_low = int'(d_hcount);
        end
        if (d_red != 4'h0) red_nz++;
        if (d_blue == 4'hA) blue_a++;
        if (d_green != 4'h0) green_nz++;
        if (d_vid) vid++;
      end else if (!prev_tick && cur_o != prev_o) begin
        hold_err++;
      end
      prev_tick = d_tick;
      prev_o    = cur_o;
      @(negedge clk);
      clks++;
    end while (!(d_tick && d_hcount == 10'd0) && clks < 4000);
    check("line_clks", clks, 3200);
    check("line_ticks", ticks, 800);
    check("hsync_low_pixels", hs_low, 96);
    check("hsync_first_low_hcount", first_low, 657);
    check("line_red_pixels", red_nz, 640);
    check("line_blue_pixels", blue_a, 640);
    check("line_green_pixels", green_nz, 0);
    check("line_video_on", vid, 640);
    check("hold_between_ticks", hold_err, 0);
    check("line_next_vcount", d_vcount, 2);

    // Asynchronous reset mid-line inside hsync
    seek_d(700, 2, 4000, ok);
    check("seek_h700", ok, 1);
    check("pre_rst_hsync_d", d_hs, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_d_hcount", d_hcount, 0);
    check("arst_d_vcount", d_vcount, 0);
    check("arst_d_tick", d_tick, 0);
    check("arst_d_fs", d_fs, 0);
    check("arst_d_hsync", d_hs, 1);
    check("arst_d_vsync", d_vs, 1);
    check("arst_s_hcount", s_hcount, 0);
    @(negedge clk);
    rst = 1'b0;
    first_ticks(de, se, dfs, sfs, dhv);
    check("restart_edge_d", de, 4);
    check("restart_fs_d", dfs, 1);
    check("restart_pos_d", dhv, 0);
    check("restart_edge_s", se, 3);

    // Vector table on the small instance, in frame order
    for (int i = 0; i < 16; i++) begin
      seek_s(vecs[i].h, vecs[i].v, 2000, ok);
      check($sformatf("v%0d_seek", i), ok, 1);
      pix_r = vecs[i].r; pix_g = vecs[i].g; pix_b = vecs[i].b;
      check($sformatf("v%0d_video_on", i), s_vid, vecs[i].vid);
      check($sformatf("v%0d_frame_start", i), s_fs, vecs[i].fs);
      @(negedge clk);
      check($sformatf("v%0d_hsync", i), s_hs, vecs[i].hs);
      check($sformatf("v%0d_vsync", i), s_vs, vecs[i].vs);
      check($sformatf("v%0d_red", i), s_red, vecs[i].er);
      check($sformatf("v%0d_green", i), s_green, vecs[i].eg);
      check($sformatf("v%0d_blue", i), s_blue, vecs[i].eb);
    end

    // One full small frame
    seek_s(0, 0, 2000, ok);
    check("seek_frame_start", ok, 1);
    clks = 0; ticks = 0; vid = 0; vs_lines = 0; first_vs = -1;
    do begin
      if (s_tick) begin
        ticks++;
        if (s_vid) vid++;
        if (s_hcount == 10'd1 && s_vs) begin
          vs_lines++;
          if (first_vs < 0) first_vs = int'(s_vcount);
        end
      end
      @(negedge clk);
      clks++;
    end while (!s_fs && clks < 2000);
    check("frame_clks", clks, 864);
    check("frame_ticks", ticks, 288);
    check("frame_video_on", vid, 96);
    check("vsync_lines", vs_lines, 2);
    check("vsync_first_line", first_vs, 8);

    // Asynchronous reset while colour is being driven
    pix_r = 4'hF; pix_g = 4'h0; pix_b = 4'hA;
    seek_s(5, 3, 2000, ok);
    check("seek_s_5_3", ok, 1);
    @(negedge clk);
    check("pre_rst_red_s", s_red, 15);
    #2 rst = 1'b1;
    #1;
    check("arst_s_red", s_red, 0);
    check("arst_s_blue", s_blue, 0);
    check("arst_s_hcount2", s_hcount, 0);
    check("arst_s_vcount", s_vcount, 0);
    check("arst_s_vsync", s_vs, 0);
    @(negedge clk);
    rst = 1'b0;
    first_ticks(de, se, dfs, sfs, dhv);
    check("restart2_edge_s", se, 3);
    check("restart2_fs_s", sfs, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
